// File: rtl/systolic_result_collector.sv
// systolic_result_collector
//   Collects the row-skewed accumulator stream of the Tile systolic array,
//   deskews it into NxN tiles held in two banks, requantizes every 32-bit
//   accumulator to int8 and streams one packed tile row per output word.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   start               1-cycle pulse: flush banks/counters, latch layer config
//   TileCount           tiles per layer (0 behaves as 1), sampled on start
//   quant_scale/shift/bias  requantization config, sampled on start
//   PE_OUT_r, resultVaild_r row r accumulator value and strobe (row r lags r-1)
//   mData/mValid/mReady/mLast  output word stream, byte c = column c
//   overflow            sticky: a tile arrived while both banks were full
//   busy                bank full, tile being captured or tile being drained
module systolic_result_collector #(
  parameter int unsigned N     = 8,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] TileCount,
  input  logic [15:0]      quant_scale,
  input  logic [4:0]       quant_shift,
  input  logic [ACC_W-1:0] quant_bias,
  input  logic [ACC_W-1:0] PE_OUT_0,
  input  logic [ACC_W-1:0] PE_OUT_1,
  input  logic [ACC_W-1:0] PE_OUT_2,
  input  logic [ACC_W-1:0] PE_OUT_3,
  input  logic [ACC_W-1:0] PE_OUT_4,
  input  logic [ACC_W-1:0] PE_OUT_5,
  input  logic [ACC_W-1:0] PE_OUT_6,
  input  logic [ACC_W-1:0] PE_OUT_7,
  input  logic             resultVaild_0,
  input  logic             resultVaild_1,
  input  logic             resultVaild_2,
  input  logic             resultVaild_3,
  input  logic             resultVaild_4,
  input  logic             resultVaild_5,
  input  logic             resultVaild_6,
  input  logic             resultVaild_7,
  output logic [8*N-1:0]   mData,
  output logic             mValid,
  input  logic             mReady,
  output logic             mLast,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned CW = $clog2(N);
  localparam int unsigned PW = ACC_W + 18;

  typedef enum logic [1:0] {RD_IDLE, RD_LOAD, RD_HOLD} rd_state_e;

  // ---------------------------------------------------------------------------
  // Requantization: ((acc + bias) * scale + round) >>> shift, saturated to int8
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] requant(input logic [ACC_W-1:0] acc,
                                         input logic [ACC_W-1:0] bias,
                                         input logic [15:0]      scale,
                                         input logic [4:0]       shift);
    localparam logic signed [PW-1:0] ONE    = 1;
    localparam logic signed [PW-1:0] SAT_HI = 127;
    localparam logic signed [PW-1:0] SAT_LO = -128;
    logic signed [ACC_W:0]  sum;
    logic signed [PW-1:0]   t;
    sum = $signed({acc[ACC_W-1], acc}) + $signed({bias[ACC_W-1], bias});
    t   = PW'(sum) * PW'($signed({1'b0, scale}));
    if (shift != 5'd0) t = t + (ONE << (shift - 5'd1));
    t = t >>> shift;
    if (t > SAT_HI)      requant = 8'h7F;
    else if (t < SAT_LO) requant = 8'h80;
    else                 requant = t[7:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Input gathering
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] pe_out [N];
  logic [N-1:0]     pe_vld;

  assign pe_out[0] = PE_OUT_0;
  assign pe_out[1] = PE_OUT_1;
  assign pe_out[2] = PE_OUT_2;
  assign pe_out[3] = PE_OUT_3;
  assign pe_out[4] = PE_OUT_4;
  assign pe_out[5] = PE_OUT_5;
  assign pe_out[6] = PE_OUT_6;
  assign pe_out[7] = PE_OUT_7;
  assign pe_vld = {resultVaild_7, resultVaild_6, resultVaild_5, resultVaild_4,
                   resultVaild_3, resultVaild_2, resultVaild_1, resultVaild_0};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0]    col_q [N];
  logic [CW-1:0]    col_d [N];
  logic [N-1:0]     row_bank_q, row_bank_d;
  logic [N-1:0]     row_drop_q, row_drop_d;
  logic             alloc_q, alloc_d;
  logic [1:0]       full_q, full_d;
  logic             overflow_q, overflow_d;
  logic             busy_q, busy_d;

  logic [15:0]      scale_q, scale_d;
  logic [4:0]       shift_q, shift_d;
  logic [ACC_W-1:0] bias_q, bias_d;
  logic [CNT_W-1:0] tc_q, tc_d;

  rd_state_e        rd_state_q, rd_state_d;
  logic [CW-1:0]    rd_row_q, rd_row_d;
  logic             rbank_q, rbank_d;
  logic [CNT_W-1:0] tile_q, tile_d;
  logic [8*N-1:0]   mdata_q, mdata_d;
  logic             mvalid_q, mvalid_d;
  logic             mlast_q, mlast_d;

  logic [N-1:0]     wr_en;
  logic [N-1:0]     wr_bank;
  logic [1:0]       set_full;
  logic [1:0]       clr_full;
  logic [CW-1:0]    rd_row_sel;
  logic [8*N-1:0]   row_word;
  logic             tile_is_last;
  logic             capturing;

  logic [ACC_W-1:0] bank_mem [2][N][N];

  // ---------------------------------------------------------------------------
  // Capture
  // Because of the row skew, row 0 of the next tile starts before row 7 of the
  // current one has finished, so a single write-bank pointer cannot serve all
  // rows. The bank/discard decision is taken when row 0 opens a tile and is
  // handed down one row per cycle as each row opens the same tile.
  // ---------------------------------------------------------------------------
  always_comb begin
    col_d      = col_q;
    row_bank_d = row_bank_q;
    row_drop_d = row_drop_q;
    alloc_d    = alloc_q;
    overflow_d = overflow_q;
    scale_d    = scale_q;
    shift_d    = shift_q;
    bias_d     = bias_q;
    tc_d       = tc_q;
    wr_en      = '0;
    wr_bank    = '0;
    set_full   = '0;

    if (pe_vld[0] && col_q[0] == '0) begin
      row_bank_d[0] = alloc_q;
      row_drop_d[0] = full_q[alloc_q];
      if (full_q[alloc_q]) overflow_d = 1'b1;
      else                 alloc_d    = ~alloc_q;
    end

    for (int unsigned r = 1; r < N; r++) begin
      if (pe_vld[r] && col_q[r] == '0) begin
        row_bank_d[r] = row_bank_q[r-1];
        row_drop_d[r] = row_drop_q[r-1];
      end
    end

    for (int unsigned r = 0; r < N; r++) begin
      if (pe_vld[r]) begin
        col_d[r]   = col_q[r] + CW'(1);
        wr_en[r]   = ~row_drop_d[r];
        wr_bank[r] = row_bank_d[r];
      end
    end

    if (pe_vld[N-1] && col_q[N-1] == CW'(N-1) && !row_drop_d[N-1])
      set_full[row_bank_d[N-1]] = 1'b1;

    // Rows still marked "drop" after a flush ignore any leftover strobes of
    // the interrupted tile until row 0 opens a fresh one.
    if (start) begin
      col_d      = '{default: '0};
      row_bank_d = '0;
      row_drop_d = '1;
      alloc_d    = 1'b0;
      overflow_d = 1'b0;
      wr_en      = '0;
      set_full   = '0;
      scale_d    = quant_scale;
      shift_d    = quant_shift;
      bias_d     = quant_bias;
      tc_d       = (TileCount == '0) ? CNT_W'(1) : TileCount;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned r = 0; r < N; r++) begin
      if (wr_en[r]) bank_mem[wr_bank[r]][r][col_q[r]] <= pe_out[r];
    end
  end

  // ---------------------------------------------------------------------------
  // Readout: LOAD fetches row 0; in HOLD an accepted word directly fetches the
  // next row so that a tile streams at one word per cycle.
  // ---------------------------------------------------------------------------
  assign rd_row_sel   = (rd_state_q == RD_HOLD) ? rd_row_q + CW'(1) : rd_row_q;
  assign tile_is_last = (tile_q == tc_q - CNT_W'(1));

  always_comb begin
    row_word = '0;
    for (int unsigned c = 0; c < N; c++)
      row_word[8*c +: 8] = requant(bank_mem[rbank_q][rd_row_sel][c],
                                   bias_q, scale_q, shift_q);
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_row_d   = rd_row_q;
    rbank_d    = rbank_q;
    tile_d     = tile_q;
    mdata_d    = mdata_q;
    mvalid_d   = mvalid_q;
    mlast_d    = mlast_q;
    clr_full   = '0;

    case (rd_state_q)
      RD_IDLE: begin
        if (full_q[rbank_q]) begin
          rd_state_d = RD_LOAD;
          rd_row_d   = '0;
        end
      end
      RD_LOAD: begin
        mdata_d    = row_word;
        mvalid_d   = 1'b1;
        mlast_d    = (rd_row_sel == CW'(N-1)) && tile_is_last;
        rd_state_d = RD_HOLD;
      end
      RD_HOLD: begin
        if (mReady) begin
          if (rd_row_q == CW'(N-1)) begin
            clr_full[rbank_q] = 1'b1;
            rbank_d    = ~rbank_q;
            tile_d     = tile_is_last ? '0 : tile_q + CNT_W'(1);
            mvalid_d   = 1'b0;
            mlast_d    = 1'b0;
            rd_state_d = RD_IDLE;
          end else begin
            rd_row_d = rd_row_sel;
            mdata_d  = row_word;
            mlast_d  = (rd_row_sel == CW'(N-1)) && tile_is_last;
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase

    if (start) begin
      rd_state_d = RD_IDLE;
      rd_row_d   = '0;
      rbank_d    = 1'b0;
      tile_d     = '0;
      mdata_d    = '0;
      mvalid_d   = 1'b0;
      mlast_d    = 1'b0;
      clr_full   = '0;
    end
  end

  // Capture completion and readout release always target opposite banks.
  always_comb begin
    full_d = start ? 2'b00 : ((full_q & ~clr_full) | set_full);
    capturing = 1'b0;
    for (int unsigned r = 0; r < N; r++)
      if (col_d[r] != '0 && !row_drop_d[r]) capturing = 1'b1;
    busy_d = (|full_d) || (rd_state_d != RD_IDLE) || capturing;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q      <= '{default: '0};
      row_bank_q <= '0;
      row_drop_q <= '1;
      alloc_q    <= 1'b0;
      full_q     <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      scale_q    <= 16'd1;
      shift_q    <= '0;
      bias_q     <= '0;
      tc_q       <= CNT_W'(1);
      rd_state_q <= RD_IDLE;
      rd_row_q   <= '0;
      rbank_q    <= 1'b0;
      tile_q     <= '0;
      mdata_q    <= '0;
      mvalid_q   <= 1'b0;
      mlast_q    <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_bank_q <= row_bank_d;
      row_drop_q <= row_drop_d;
      alloc_q    <= alloc_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      scale_q    <= scale_d;
      shift_q    <= shift_d;
      bias_q     <= bias_d;
      tc_q       <= tc_d;
      rd_state_q <= rd_state_d;
      rd_row_q   <= rd_row_d;
      rbank_q    <= rbank_d;
      tile_q     <= tile_d;
      mdata_q    <= mdata_d;
      mvalid_q   <= mvalid_d;
      mlast_q    <= mlast_d;
    end
  end

  assign mData    = mdata_q;
  assign mValid   = mvalid_q;
  assign mLast    = mlast_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;

endmodule
